mygo_fifo_flow: RTL and testbench

//   Parametrised synchronous FIFO for channel links between generated process modules.

---
 rtl/mygo_fifo_pkg.sv | 27 ++
 rtl/mygo_fifo_ptr.sv | 36 +++
 rtl/mygo_fifo_flow.sv | 156 +++++++++++++++
 tb/tb_mygo_fifo_flow.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mygo_fifo_pkg.sv
// -----------------------------------------------------------------------------
// mygo_fifo_pkg
//   Shared definitions for the mygo channel FIFO.
//   - addr_bits()  : pointer width for a given depth (minimum 1 bit)
//   - count_bits() : occupancy width able to hold 0..depth (minimum 1 bit)
//   - fifo_op_e    : per-cycle handshake outcome, drives the occupancy update
// -----------------------------------------------------------------------------
package mygo_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_BOTH = 2'd3
    } fifo_op_e;

    function automatic int addr_bits(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int count_bits(input int depth);
        int b;
        b = $clog2(depth + 1);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/mygo_fifo_ptr.sv
// -----------------------------------------------------------------------------
// mygo_fifo_ptr
//   Circular pointer register that wraps from DEPTH-1 back to 0.
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   asynchronous reset, active-low (pointer -> 0)
//     clear    in   synchronous return to 0, wins over advance
//     advance  in   step the pointer by one slot
//     ptr      out  current slot index
//   With DEPTH==1 the wrap value is 0, so the pointer stays at 0.
// -----------------------------------------------------------------------------
module mygo_fifo_ptr #(
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 advance,
    output logic [ADDR_BITS-1:0] ptr
);

    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] ONE  = ADDR_BITS'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == LAST) ? '0 : ptr + ONE;
        end
    end

endmodule

// File: rtl/mygo_fifo_flow.sv
// -----------------------------------------------------------------------------
// mygo_fifo_flow
//   Synchronous valid/ready FIFO for channel links between process modules,
//   with occupancy count, almost-full/almost-empty flags, synchronous flush
//   and an optional full-bypass push.
//   Ports:
//     clk           in   sole clock, rising edge
//     rst           in   asynchronous reset, active-low
//     flush         in   synchronous clear of all contents
//     in_data       in   write data (WIDTH)
//     in_valid      in   producer has data
//     in_ready      out  FIFO accepts data this cycle
//     out_data      out  head entry, 0 when out_valid is low
//     out_valid     out  head entry valid
//     out_ready     in   consumer takes head this cycle
//     count         out  occupancy 0..DEPTH (COUNT_BITS)
//     almost_full   out  count >= AFULL_THRESH
//     almost_empty  out  count <= AEMPTY_THRESH
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high (push = in_valid & in_ready, pop = out_valid & out_ready).
//   valid never waits on ready; ready may depend on the opposite side's ready
//   only in the full-bypass build (out_ready -> in_ready when full). While
//   flush is high both in_ready and out_valid are forced low, so no transfer
//   completes in a flush cycle. No same-cycle fall-through: data pushed into
//   an empty FIFO appears on out_valid one cycle later.
// -----------------------------------------------------------------------------
module mygo_fifo_flow
    import mygo_fifo_pkg::*;
#(
    parameter  int WIDTH         = 32,
    parameter  int DEPTH         = 4,
    parameter  int AFULL_THRESH  = DEPTH - 1,
    parameter  int AEMPTY_THRESH = 1,
    parameter  int FULL_BYPASS   = 0,
    localparam int ADDR_BITS     = addr_bits(DEPTH),
    localparam int COUNT_BITS    = count_bits(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COUNT_BITS-1:0] count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    if (DEPTH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_params
        $error("mygo_fifo_flow: illegal parameters (DEPTH must be >=1, AFULL_THRESH <= DEPTH)");
    end

    localparam logic [COUNT_BITS-1:0] DEPTH_C = COUNT_BITS'(DEPTH);
    localparam logic [COUNT_BITS-1:0] ONE_C   = COUNT_BITS'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_BITS-1:0]  wptr;
    logic [ADDR_BITS-1:0]  rptr;
    logic [COUNT_BITS-1:0] count_q;
    logic                  is_empty;
    logic                  is_full;
    logic                  push;
    logic                  pop;
    fifo_op_e              op;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);

    // Occupancy never exceeds DEPTH, so "not full" is the same as count < DEPTH.
    if (FULL_BYPASS != 0) begin : g_bypass
        assign in_ready = ~flush & (~is_full | out_ready);
    end else begin : g_no_bypass
        assign in_ready = ~flush & ~is_full;
    end

    assign out_valid = ~is_empty & ~flush;
    assign out_data  = out_valid ? mem[rptr] : '0;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        op = OP_IDLE;
        case ({pop, push})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            case (op)
                OP_PUSH: count_q <= count_q + ONE_C;
                OP_POP:  count_q <= count_q - ONE_C;
                default: count_q <= count_q;
            endcase
        end
    end

    // In the full-bypass case wptr == rptr, so the write reuses the slot
    // whose contents are being handed out in the same cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    mygo_fifo_ptr #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_wptr (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .advance (push),
        .ptr     (wptr)
    );

    mygo_fifo_ptr #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_rptr (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .advance (pop),
        .ptr     (rptr)
    );

    assign count = count_q;

    if (AFULL_THRESH <= 0) begin : g_afull_const
        assign almost_full = 1'b1;
    end else begin : g_afull_cmp
        assign almost_full = (count_q >= COUNT_BITS'(AFULL_THRESH));
    end

    if (AEMPTY_THRESH >= DEPTH) begin : g_aempty_const
        assign almost_empty = 1'b1;
    end else if (AEMPTY_THRESH < 0) begin : g_aempty_never
        assign almost_empty = 1'b0;
    end else begin : g_aempty_cmp
        assign almost_empty = (count_q <= COUNT_BITS'(AEMPTY_THRESH));
    end

endmodule

// File: tb/tb_mygo_fifo_flow.sv
// -----------------------------------------------------------------------------
// tb_mygo_fifo_flow
//   Three FIFO builds side by side, exercised one at a time:
//     u0 : DEPTH=4, FULL_BYPASS=0
//     u1 : DEPTH=4, FULL_BYPASS=1
//     u2 : DEPTH=3, FULL_BYPASS=0
//   The reference model is a queue of stored words (exp_q); expected port
//   values come from its size and head, using the FIFO's stated rules.
// -----------------------------------------------------------------------------
module tb_mygo_fifo_flow;

    logic        clk;
    logic        rst;
    logic        flush        [3];
    logic [31:0] in_data      [3];
    logic        in_valid     [3];
    logic        in_ready     [3];
    logic [31:0] out_data     [3];
    logic        out_valid    [3];
    logic        out_ready    [3];
    logic [2:0]  count        [3];
    logic        almost_full  [3];
    logic        almost_empty [3];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    mygo_fifo_flow #(.WIDTH(32), .DEPTH(4), .FULL_BYPASS(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .count(count[0]), .almost_full(almost_full[0]), .almost_empty(almost_empty[0])
    );

    mygo_fifo_flow #(.WIDTH(32), .DEPTH(4), .FULL_BYPASS(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .count(count[1]), .almost_full(almost_full[1]), .almost_empty(almost_empty[1])
    );

    mygo_fifo_flow #(.WIDTH(32), .DEPTH(3), .FULL_BYPASS(0)) u2 (
        .clk(clk), .rst(rst), .flush(flush[2]),
        .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .count(count[2]), .almost_full(almost_full[2]), .almost_empty(almost_empty[2])
    );

    function automatic int depth_of(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic bit bypass_of(input int k);
        return (k == 1);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            flush[k]     = 1'b0;
            in_data[k]   = '0;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
    endtask

    // Called at a falling edge: drive one cycle on instance k, check every
    // output against the model, clock it, update the model, return inputs idle.
    task automatic step(input int k, input logic v, input logic [31:0] d,
                        input logic r, input logic fl);
        int          cnt;
        int          depth;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        depth = depth_of(k);
        cnt   = exp_q.size();
        in_valid[k]  = v;
        in_data[k]   = d;
        out_ready[k] = r;
        flush[k]     = fl;
        #1;
        e_ir = !fl && ((cnt < depth) || (bypass_of(k) && r && cnt == depth));
        e_ov = !fl && (cnt != 0);
        e_od = e_ov ? exp_q[0] : 32'd0;
        check($sformatf("u%0d.in_ready", k),     32'(in_ready[k]),     32'(e_ir));
        check($sformatf("u%0d.out_valid", k),    32'(out_valid[k]),    32'(e_ov));
        check($sformatf("u%0d.out_data", k),     out_data[k],          e_od);
        check($sformatf("u%0d.count", k),        32'(count[k]),        32'(cnt));
        check($sformatf("u%0d.almost_full", k),  32'(almost_full[k]),  32'(cnt >= depth - 1));
        check($sformatf("u%0d.almost_empty", k), 32'(almost_empty[k]), 32'(cnt <= 1));
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (e_ov && r) void'(exp_q.pop_front());
            if (v && e_ir) exp_q.push_back(d);
        end
        #1;
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        flush[k]     = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input int k);
        for (int g = 0; g < 8 && exp_q.size() > 0; g++) step(k, 1'b0, 32'd0, 1'b1, 1'b0);
        step(k, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_all();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();

        // Reset state on all builds
        for (int k = 0; k < 3; k++) step(k, 1'b0, 32'd0, 1'b0, 1'b0);

        // Fill 5..8 with no consumer, try one more while full, then drain
        for (int i = 0; i < 4; i++) step(0, 1'b1, 32'(5 + i), 1'b0, 1'b0);
        step(0, 1'b1, 32'd99, 1'b0, 1'b0);
        step(0, 1'b1, 32'd98, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(0, 1'b0, 32'd0, 1'b1, 1'b0);

        // DEPTH=3 full-rate stream 0..9 across the wrap
        step(2, 1'b1, 32'd0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) step(2, 1'b1, 32'(i), 1'b1, 1'b0);
        step(2, 1'b0, 32'd0, 1'b1, 1'b0);
        step(2, 1'b0, 32'd0, 1'b0, 1'b0);

        // Full bypass: fill 1..4, push 9 while popping, drain 2,3,4,9
        for (int i = 1; i <= 4; i++) step(1, 1'b1, 32'(i), 1'b0, 1'b0);
        step(1, 1'b1, 32'd9, 1'b1, 1'b0);
        drain(1);

        // Flush with two entries and a pending push
        step(0, 1'b1, 32'd1, 1'b0, 1'b0);
        step(0, 1'b1, 32'd2, 1'b0, 1'b0);
        step(0, 1'b1, 32'd3, 1'b1, 1'b1);
        step(0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(0, 1'b1, 32'hA5, 1'b0, 1'b0);
        drain(0);

        // Asynchronous reset mid-stream with three entries
        for (int i = 0; i < 3; i++) step(0, 1'b1, 32'(40 + i), 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("rst.count",        32'(count[0]),        32'd0);
        check("rst.in_ready",     32'(in_ready[0]),     32'd1);
        check("rst.out_valid",    32'(out_valid[0]),    32'd0);
        check("rst.out_data",     out_data[0],          32'd0);
        check("rst.almost_empty", 32'(almost_empty[0]), 32'd1);
        check("rst.almost_full",  32'(almost_full[0]),  32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        step(0, 1'b1, 32'h11, 1'b0, 1'b0);
        step(0, 1'b1, 32'h22, 1'b0, 1'b0);
        drain(0);

        // Randomized traffic on each build
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 400; n++) begin
                step(k, 1'($urandom_range(0, 1)), $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
            end
            drain(k);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
